// File: rtl/serial_alu64.sv
// Bit-serial 64-bit ALU: ADD / SUB (a + ~b + cin) / OR / XOR.
// One result bit per clock, LSB first, with a single carry flop between cycles.
module serial_alu64 #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [1:0]       op,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [1:0]       r_op;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic w_accept;
  logic w_last;
  logic w_bit_a;
  logic w_bit_b;
  logic w_sum;
  logic w_carry;
  logic w_bit;

  assign w_accept = (r_state == IDLE) && start;
  assign w_last   = (r_state == RUN) && (r_cnt == LAST);

  // Bit-slice: op 01 adds the inverted B bit; logic ops ignore the carry chain.
  always_comb begin
    w_bit_a = r_a[0];
    w_bit_b = (r_op == 2'b01) ? ~r_b[0] : r_b[0];
    w_sum   = w_bit_a ^ w_bit_b ^ r_carry;
    w_carry = (w_bit_a & w_bit_b) | (w_bit_a & r_carry) | (w_bit_b & r_carry);
    case (r_op)
      2'b00, 2'b01: w_bit = w_sum;
      2'b10:        w_bit = r_a[0] | r_b[0];
      default:      w_bit = r_a[0] ^ r_b[0];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? RUN : IDLE;
      RUN:     w_next = w_last ? DONE : RUN;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    ready = (r_state == IDLE);
    done  = (r_state == DONE);
  end

  // Partial results accumulate in r_res; s/cout only move on the final bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_op    <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      s       <= '0;
      cout    <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_op    <= op;
      r_carry <= cin;
      r_res   <= '0;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_res   <= {w_bit, r_res[WIDTH-1:1]};
      r_carry <= w_carry;
      if (w_last) begin
        s    <= {w_bit, r_res[WIDTH-1:1]};
        cout <= r_op[1] ? 1'b0 : w_carry;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_serial_alu64.sv
// Self-checking bench for serial_alu64: directed vector table, random ops
// against an arithmetic reference model, and multi-cycle corner sequences.
module tb_serial_alu64;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [63:0] a;
  logic [63:0] b;
  logic        cin;
  logic [1:0]  op;
  logic        ready;
  logic        done;
  logic [63:0] s;
  logic        cout;

  int checks   = 0;
  int failures = 0;

  serial_alu64 #(.WIDTH(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .op    (op),
    .ready (ready),
    .done  (done),
    .s     (s),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic [1:0]  op;
    logic [63:0] es;
    logic        ec;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic void model(input logic [63:0] ma, input logic [63:0] mb, input logic mc,
                                input logic [1:0] mop, output logic [63:0] ms, output logic mco);
    logic [64:0] wide;
    case (mop)
      2'b00: begin wide = {1'b0, ma} + {1'b0, mb} + 65'(mc);  ms = wide[63:0]; mco = wide[64]; end
      2'b01: begin wide = {1'b0, ma} + {1'b0, ~mb} + 65'(mc); ms = wide[63:0]; mco = wide[64]; end
      2'b10: begin ms = ma | mb; mco = 1'b0; end
      default: begin ms = ma ^ mb; mco = 1'b0; end
    endcase
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic scramble();
    a   = rnd64();
    b   = rnd64();
    cin = 1'($urandom);
    op  = 2'($urandom);
  endtask

  // One complete operation; operands are scrambled right after acceptance.
  task automatic do_op(input logic [63:0] ta, input logic [63:0] tb_v, input logic tc,
                       input logic [1:0] top, output logic [63:0] rs, output logic rc,
                       output int lat);
    logic [63:0] s_before;
    logic        c_before;
    bit          stable;
    int          n;
    @(negedge clk);
    n = 0;
    while (!ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 64'(ready), 64'd1);
    s_before = s;
    c_before = cout;
    a = ta; b = tb_v; cin = tc; op = top; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    scramble();
    check("accept", 64'(ready), 64'd0);
    stable = 1'b1;
    lat = -1;
    for (int e = 1; e <= 200; e++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = e;
        break;
      end
      if (s !== s_before || cout !== c_before) stable = 1'b0;
    end
    rs = s;
    rc = cout;
    check("hold_during_run", 64'(stable), 64'd1);
    @(posedge clk);
    #1;
    check("pulse_end", {62'd0, done, ready}, 64'b01);
  endtask

  logic [63:0] rs, es;
  logic        rc, ec;
  int          lat;

  initial begin
    vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 2'b00, 64'd0, 1'b1};
    vecs[1] = '{64'd5, 64'd7, 1'b1, 2'b01, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
    vecs[2] = '{64'd7, 64'd5, 1'b1, 2'b01, 64'd2, 1'b1};
    vecs[3] = '{64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 1'b0, 2'b11,
                64'h0FF0_0FF0_0FF0_0FF0, 1'b0};
    vecs[4] = '{64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 1'b1, 2'b10,
                64'hFFF0_FFF0_FFF0_FFF0, 1'b0};
    vecs[5] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 2'b00, 64'd1, 1'b1};
    vecs[6] = '{64'd0, 64'd0, 1'b0, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[7] = '{64'd0, 64'd0, 1'b1, 2'b10, 64'd0, 1'b0};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; op = 2'b00;
    #1;
    check("reset_s", s, 64'd0);
    check("reset_cout", 64'(cout), 64'd0);
    check("reset_ready_done", {62'd0, ready, done}, 64'b10);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].op, rs, rc, lat);
      check($sformatf("vec%0d_s", i), rs, vecs[i].es);
      check($sformatf("vec%0d_cout", i), 64'(rc), 64'(vecs[i].ec));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd64);
    end

    for (int i = 0; i < 10; i++) begin
      logic [63:0] ra, rb;
      logic        rcin;
      logic [1:0]  rop;
      ra = rnd64(); rb = rnd64(); rcin = 1'($urandom); rop = 2'($urandom);
      model(ra, rb, rcin, rop, es, ec);
      do_op(ra, rb, rcin, rop, rs, rc, lat);
      check($sformatf("rand%0d_s", i), rs, es);
      check($sformatf("rand%0d_cout", i), 64'(rc), 64'(ec));
    end

    // Busy protection: a second start during RUN must be ignored.
    begin
      logic [63:0] ba, bb;
      int dcount;
      ba = rnd64() | 64'h1; bb = rnd64();
      model(ba, bb, 1'b0, 2'b00, es, ec);
      @(negedge clk);
      a = ba; b = bb; cin = 1'b0; op = 2'b00; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      a = '0; b = '0; op = 2'b11; cin = 1'b1; start = 1'b1;
      dcount = 0;
      for (int c = 0; c < 140; c++) begin
        @(posedge clk);
        #1;
        if (c == 5) start = 1'b0;
        if (done) begin
          dcount++;
          check("busy_s", s, es);
          check("busy_cout", 64'(cout), 64'(ec));
        end
      end
      check("busy_done_count", 64'(dcount), 64'd1);
      check("busy_idle", 64'(ready), 64'd1);
    end

    // Reset mid-operation: discarded, outputs cleared at once.
    begin
      int dcount;
      @(negedge clk);
      a = 64'd100; b = 64'd200; cin = 1'b0; op = 2'b00; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (30) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_s", s, 64'd0);
      check("midrst_cout", 64'(cout), 64'd0);
      check("midrst_ready_done", {62'd0, ready, done}, 64'b10);
      @(negedge clk);
      rst_n = 1'b1;
      dcount = 0;
      for (int c = 0; c < 80; c++) begin
        @(posedge clk);
        #1;
        if (done) dcount++;
      end
      check("midrst_no_done", 64'(dcount), 64'd0);
      do_op(64'd3, 64'd4, 1'b0, 2'b00, rs, rc, lat);
      check("post_rst_s", rs, 64'd7);
      check("post_rst_cout", 64'(rc), 64'd0);
      check("post_rst_latency", 64'(lat), 64'd64);
    end

    // Back-to-back with start held high.
    begin
      logic [63:0] q_s[$];
      logic        q_c[$];
      int acc, dn, last_done;
      acc = 0; dn = 0; last_done = -1;
      @(negedge clk);
      scramble();
      start = 1'b1;
      for (int c = 0; c < 400 && dn < 3; c++) begin
        if (c > 0) @(negedge clk);
        if (done) begin
          if (q_s.size() > 0) begin
            check($sformatf("b2b%0d_s", dn), s, q_s.pop_front());
            check($sformatf("b2b%0d_cout", dn), 64'(cout), 64'(q_c.pop_front()));
          end else begin
            check("b2b_unexpected_done", 64'd1, 64'd0);
          end
          if (dn > 0) check("b2b_gap", 64'(c - last_done), 64'd66);
          last_done = c;
          dn++;
        end
        if (ready && acc < 3) begin
          model(a, b, cin, op, es, ec);
          q_s.push_back(es);
          q_c.push_back(ec);
          acc++;
        end else if (!ready) begin
          scramble();
          if (acc == 3) start = 1'b0;
        end
      end
      start = 1'b0;
      check("b2b_done_count", 64'(dn), 64'd3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_alu64.md
SERIAL_ALU64 -- requirements
Module: serial_alu64

Interface
REQ-001 Parameter WIDTH, default 64, is the operand and result width in bits; WIDTH SHALL be >= 2.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to begin an operation; sampled only when ready=1.
REQ-005 a  input  WIDTH  operand A; sampled on the accepting edge only.
REQ-006 b  input  WIDTH  operand B; sampled on the accepting edge only.
REQ-007 cin  input  1  carry in; sampled on the accepting edge only.
REQ-008 op  input  2  operation select; sampled on the accepting edge only.
REQ-009 ready  output  1  high when idle and able to accept start.
REQ-010 done  output  1  single-cycle pulse marking a valid new result.
REQ-011 s  output  WIDTH  registered result.
REQ-012 cout  output  1  registered carry out.

Function
REQ-013 Ops SHALL be:
- 00: s = a + b + cin.
- 01: s = a + ~b + cin (a-b when cin=1).
- 10: s = a | b.
- 11: s = a ^ b.
REQ-014 For ops 00/01, cout SHALL be the carry out of bit WIDTH-1; for ops 10/11, cout SHALL be 0.
REQ-015 Operations SHALL be computed bit-serially: one full-adder/logic bit per cycle, LSB first, with a 1-bit carry register between cycles.
REQ-016 FSM states SHALL be IDLE, RUN and DONE; ready SHALL equal (state==IDLE).
REQ-017 IDLE: if start=1 at an edge, the block SHALL:
- latch a, b, op and cin into internal registers;
- load carry with cin and clear the bit counter;
- enter RUN.
Otherwise it SHALL stay in IDLE.
REQ-018 RUN: each edge SHALL process one bit and increment the counter; the edge that processes bit WIDTH-1 SHALL load s and cout and enter DONE.
REQ-019 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-020 Latency: done SHALL be high in the cycle following the WIDTH-th rising edge after the accepting edge (64 for default WIDTH).
REQ-021 With start held high continuously, successive operations SHALL be accepted every WIDTH+2 cycles.
REQ-022 start while in RUN or DONE SHALL be ignored and not queued.
REQ-023 Changes on a, b, cin or op after acceptance SHALL NOT affect the in-flight result.
REQ-024 s and cout SHALL hold their last completed values at all times except the completion edge; partial results SHALL never appear on s.
REQ-025 The bit counter SHALL be sized ceil(log2(WIDTH)) bits and SHALL NOT wrap within an operation.

Reset
REQ-026 rst_n=0 SHALL immediately force the following, independent of clk and of the current state (including mid-RUN):
- state=IDLE;
- s=0, cout=0, done=0, ready=1;
- internal carry, counter and operand registers cleared.
REQ-027 An operation interrupted by reset SHALL be discarded; no done pulse SHALL follow.
REQ-028 The first start after rst_n rises SHALL be accepted on the first rising edge at which it is sampled high.

Verification
REQ-029 The bench SHALL cover these scenarios:
- ADD wrap: a=0xFFFF_FFFF_FFFF_FFFF, b=1, cin=0, op=00 -> s=0, cout=1, done exactly 64 edges after acceptance.
- SUB: a=5, b=7, cin=1, op=01 -> s=0xFFFF_FFFF_FFFF_FFFE, cout=0; then a=7, b=5 -> s=2, cout=1.
- XOR/OR: a=0xF0F0_F0F0_F0F0_F0F0, b=0xFF00_FF00_FF00_FF00:
  - op=11 -> s=0x0FF0_0FF0_0FF0_0FF0, cout=0;
  - op=10 -> s=0xFFF0_FFF0_FFF0_FFF0, cout=0.
- Busy protection: second start at RUN cycle 10 with a=0, b=0 and operands toggled -> ignored; first result intact; exactly one done pulse.
- Reset mid-op: rst_n low at RUN cycle 30 -> s=0, cout=0, ready=1 immediately, no done; the next ADD 3+4 -> s=7.
- Back-to-back: start held high for three random ops -> done pulses 66 cycles apart; each s/cout matches a reference model.
